data_ram_err_slave: RTL and testbench



---
 rtl/data_ram_err_slave.sv | 193 +++++++++++++++++++
 tb/tb_data_ram_err_slave.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_err_slave.sv
// -----------------------------------------------------------------------------
// data_ram_err_slave
//
// Single-port, byte-writable data RAM slave for the core's data memory bus.
// Every accepted load/store is answered after LATENCY cycles with either an
// ack pulse (serviced) or an err pulse (refused). Error sources: word index
// beyond DEPTH, an inclusive address window, an "error on the Nth accepted
// access" injector, and optionally misaligned addresses.
//
// Optional feature macro: RAM_ERR_MISALIGN_EN
//   defined   : an access errors when addr_i is not aligned to its enabled
//               bytes (halfword enables 0011/1100 need addr_i[0]=0; full-word
//               writes and all reads need addr_i[1:0]=0). Only meaningful for
//               DATA_WIDTH=32.
//   undefined : the low address bits are ignored; misaligned accesses are
//               serviced on the containing word.
//
// Ports
//   clk_i         in  clock, rising edge
//   rst_i         in  synchronous active-high reset
//   req_i         in  access request (sampled only in IDLE)
//   we_i          in  byte write enables, all-zero = read
//   addr_i        in  byte address
//   wdata_i       in  write data
//   rdata_o       out read data (0 on an error response, held otherwise)
//   ack_o         out one-cycle pulse, successful response
//   err_o         out one-cycle pulse, error response
//   busy_o        out high while the access waits for its response slot
//   err_lo_i      in  error window low bound, inclusive
//   err_hi_i      in  error window high bound, inclusive (lo > hi disables)
//   inject_nth_i  in  Nth accepted access gets an error, 0 disables
//   dbg_state_o   out current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Handshake: the master raises req_i with we_i/addr_i/wdata_i stable while the
// slave is IDLE; the request is taken on that rising edge. The master then
// keeps req_i low until it sees ack_o or err_o; requests seen in WAIT or RESP
// are ignored. Exactly one of ack_o/err_o pulses per accepted request unless
// reset intervenes, in which case the access is dropped silently.
// -----------------------------------------------------------------------------
module data_ram_err_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    busy_o,
  input  logic [ADDR_WIDTH-1:0]   err_lo_i,
  input  logic [ADDR_WIDTH-1:0]   err_hi_i,
  input  logic [CNT_WIDTH-1:0]    inject_nth_i,
  output logic [1:0]              dbg_state_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFFS  = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [BE_W-1:0]       r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_err;
  logic [3:0]            r_lat_cnt;
  logic [CNT_WIDTH-1:0]  r_acc_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic                  w_range_err;
  logic                  w_win_err;
  logic [CNT_WIDTH-1:0]  w_acc_next;
  logic                  w_inj_err;
  logic                  w_misalign;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_accept    = (r_state == S_IDLE) && req_i;
  assign w_word_idx  = addr_i >> OFFS;
  assign w_range_err = (w_word_idx >= ADDR_WIDTH'(DEPTH));
  assign w_win_err   = (err_lo_i <= err_hi_i) &&
                       (addr_i >= err_lo_i) && (addr_i <= err_hi_i);
  // The injector compares against the ordinal of the access being accepted.
  assign w_acc_next  = r_acc_cnt + CNT_WIDTH'(1);
  assign w_inj_err   = (inject_nth_i != '0) && (w_acc_next == inject_nth_i);

`ifdef RAM_ERR_MISALIGN_EN
  logic [3:0] w_we4;
  assign w_we4 = 4'(we_i);
  always_comb begin
    w_misalign = 1'b0;
    if (DATA_WIDTH == 32) begin
      if ((w_we4 == 4'b0011) || (w_we4 == 4'b1100)) begin
        w_misalign = addr_i[0];
      end else if ((w_we4 == 4'b1111) || (w_we4 == 4'b0000)) begin
        w_misalign = (addr_i[1:0] != 2'b00);
      end
    end
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_range_err | w_win_err | w_inj_err | w_misalign;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_i) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (r_lat_cnt <= 4'd1) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, captured request and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_we      <= '0;
      r_wdata   <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_lat_cnt <= '0;
      r_acc_cnt <= '0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we      <= we_i;
        r_wdata   <= wdata_i;
        r_idx     <= w_word_idx[IDX_W-1:0];
        r_err     <= w_err;
        r_acc_cnt <= w_acc_next;
        // WAIT lasts LATENCY-1 cycles; leave it when one cycle remains.
        r_lat_cnt <= 4'(LATENCY - 1);
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= r_lat_cnt - 4'd1;
      end
      if (r_state == S_RESP) begin
        r_rdata <= w_rdata;
      end
    end
  end

  // RAM write happens at the edge closing RESP, so a reset during RESP
  // still cancels it. Contents are never reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (r_state == S_RESP) && !r_err) begin
      for (int k = 0; k < BE_W; k++) begin
        if (r_we[k]) r_mem[r_idx][k*8 +: 8] <= r_wdata[k*8 +: 8];
      end
    end
  end

  // Read data: presented during RESP, then held in r_rdata. Writes leave the
  // previous value untouched; errors force zero.
  always_comb begin
    w_rdata = r_rdata;
    if (r_state == S_RESP) begin
      if (r_err) begin
        w_rdata = '0;
      end else if (r_we == '0) begin
        w_rdata = r_mem[r_idx];
      end
    end
  end

  assign rdata_o     = w_rdata;
  assign ack_o       = (r_state == S_RESP) && !r_err && !rst_i;
  assign err_o       = (r_state == S_RESP) &&  r_err && !rst_i;
  assign busy_o      = (r_state == S_WAIT);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_data_ram_err_slave.sv
// Bench for data_ram_err_slave: three instances at LATENCY 1, 4 and 8 share
// the data-side inputs; each has its own req and outputs.
module tb_data_ram_err_slave;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] err_lo;
  logic [31:0] err_hi;
  logic [15:0] inject;

  logic        req   [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];
  logic [1:0]  dbg   [3];

  data_ram_err_slave #(.LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0]),
    .busy_o(busy[0]), .err_lo_i(err_lo), .err_hi_i(err_hi),
    .inject_nth_i(inject), .dbg_state_o(dbg[0])
  );

  data_ram_err_slave #(.LATENCY(4)) u_dut_l4 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1]),
    .busy_o(busy[1]), .err_lo_i(err_lo), .err_hi_i(err_hi),
    .inject_nth_i(inject), .dbg_state_o(dbg[1])
  );

  data_ram_err_slave #(.LATENCY(8)) u_dut_l8 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata[2]), .ack_o(ack[2]), .err_o(err[2]),
    .busy_o(busy[2]), .err_lo_i(err_lo), .err_hi_i(err_hi),
    .inject_nth_i(inject), .dbg_state_o(dbg[2])
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  // ---------------- driver ----------------
  // One complete access on instance d; checks response latency, busy length,
  // response kind, optional read data and single-cycle pulse.
  task automatic access(input int d, input logic [3:0] a_we, input logic [31:0] a_addr,
                        input logic [31:0] a_wdata, input logic exp_err,
                        input logic chk_rd, input logic [31:0] exp_rd, input string tag);
    int          lat;
    int          resp_k;
    int          busy_n;
    logic        both;
    logic        got_err;
    logic [31:0] got_rd;
    lat = lat_of(d);
    @(negedge clk);
    we = a_we; addr = a_addr; wdata = a_wdata; req[d] = 1'b1;
    @(posedge clk);
    #1 req[d] = 1'b0;
    resp_k = 0; busy_n = 0; both = 1'b0; got_err = 1'b0; got_rd = '0;
    for (int k = 1; (k <= 20) && (resp_k == 0); k++) begin
      @(negedge clk);
      if (busy[d]) busy_n++;
      if (ack[d] && err[d]) both = 1'b1;
      if (ack[d] || err[d]) begin
        resp_k  = k;
        got_err = err[d];
        got_rd  = rdata[d];
      end
    end
    check({tag, ":lat"}, resp_k, lat);
    check({tag, ":excl"}, 32'(both), 32'd0);
    if (resp_k != 0) begin
      check({tag, ":busy"}, busy_n, lat - 1);
      check({tag, ":err"}, 32'(got_err), 32'(exp_err));
      if (chk_rd) check({tag, ":rdata"}, got_rd, exp_rd);
      @(posedge clk);
      #1 check({tag, ":pulse"}, 32'(ack[d] | err[d]), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  int n_resp;

  initial begin
    rst = 1'b1;
    we = '0; addr = '0; wdata = '0;
    err_lo = 32'hFFFF_FFFF; err_hi = 32'h0;  // window disabled
    inject = '0;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:ack",   32'(ack[0]),  32'd0);
    check("rst:err",   32'(err[0]),  32'd0);
    check("rst:busy",  32'(busy[1]), 32'd0);
    check("rst:state", 32'(dbg[2]),  32'd0);
    check("rst:rdata", rdata[0],     32'd0);
    rst = 1'b0;

    // Nth-access injection at LATENCY=4 (fresh counter).
    inject = 16'd3;
    access(1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "nth1");
    access(1, 4'h0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, "nth2");
    access(1, 4'h0, 32'h8, 32'h0, 1'b1, 1'b1, 32'h0, "nth3");
    access(1, 4'h0, 32'hC, 32'h0, 1'b0, 1'b0, 32'h0, "nth4");
    inject = 16'd0;

    // Full-word write then read, LATENCY=1.
    access(0, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, "wr10");
    access(0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, "rd10");

    // Byte merge.
    access(0, 4'hF, 32'h20, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, "wr20");
    access(0, 4'h1, 32'h20, 32'h0000_0012, 1'b0, 1'b0, 32'h0, "wrb20");
    access(0, 4'h0, 32'h20, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF12, "rd20");

    // Misaligned read of 0x22.
`ifdef RAM_ERR_MISALIGN_EN
    access(0, 4'h0, 32'h22, 32'h0, 1'b1, 1'b1, 32'h0, "mis22");
`else
    access(0, 4'h0, 32'h22, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF12, "mis22");
`endif
    // Upper halfword write at 0x22 is aligned in both builds.
    access(0, 4'hC, 32'h22, 32'hABCD_0000, 1'b0, 1'b0, 32'h0, "hw22");
    access(0, 4'h0, 32'h20, 32'h0, 1'b0, 1'b1, 32'hABCD_FF12, "rdhw");

    // Error window, inclusive bounds, write suppression.
    access(0, 4'hF, 32'h104, 32'h0, 1'b0, 1'b0, 32'h0, "pre104");
    err_lo = 32'h100; err_hi = 32'h1FF;
    access(0, 4'hF, 32'h104, 32'h55, 1'b1, 1'b1, 32'h0, "win104");
    access(0, 4'h0, 32'h1FC, 32'h0, 1'b1, 1'b1, 32'h0, "win1fc");
    access(0, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, "win200");
    access(0, 4'h0, 32'h0FC, 32'h0, 1'b0, 1'b0, 32'h0, "win0fc");
    err_lo = 32'hFFFF_FFFF; err_hi = 32'h0;
    access(0, 4'h0, 32'h104, 32'h0, 1'b0, 1'b1, 32'h0, "rd104");

    // Address range: last word works, first word past DEPTH errors and
    // does not alias onto word 0.
    access(0, 4'hF, 32'h0,   32'h0123_4567, 1'b0, 1'b0, 32'h0, "pre0");
    access(0, 4'hF, 32'hFFC, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, "wrffc");
    access(0, 4'h0, 32'hFFC, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, "rdffc");
    access(0, 4'hF, 32'h1000, 32'hBAD0_BAD0, 1'b1, 1'b1, 32'h0, "wr1000");
    access(0, 4'h0, 32'h1000, 32'h0, 1'b1, 1'b1, 32'h0, "rd1000");
    access(0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0123_4567, "rd0");

    // Reset mid-access at LATENCY=8.
    access(2, 4'hF, 32'h40, 32'h1111_1111, 1'b0, 1'b0, 32'h0, "pre40");
    @(negedge clk);
    we = 4'hF; addr = 32'h40; wdata = 32'hA5A5_A5A5; req[2] = 1'b1;
    @(posedge clk);
    #1 req[2] = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk) rst = 1'b1;
    n_resp = 0;
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ack[2] || err[2]) n_resp++;
    end
    check("abort8:noresp", n_resp, 0);
    check("abort8:busy", 32'(busy[2]), 32'd0);
    inject = 16'd1;
    access(2, 4'h0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h0, "abort8:inj1");
    inject = 16'd0;
    access(2, 4'h0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h1111_1111, "abort8:keep");

    // Reset coinciding with the RESP cycle at LATENCY=4.
    access(1, 4'hF, 32'h80, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0, "pre80");
    @(negedge clk);
    we = 4'hF; addr = 32'h80; wdata = 32'h7777_7777; req[1] = 1'b1;
    @(posedge clk);
    #1 req[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("resprst:state", 32'(dbg[1]), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("resprst:noresp", 32'(ack[1] | err[1]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("resprst:idle", 32'(dbg[1]), 32'd0);
    access(1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b1, 32'h5A5A_5A5A, "resprst:keep");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
